sseg_scan_dimmer: RTL and testbench
===================================

# sseg_scan_dimmer

Generates the time-multiplexed anode scan and the brightness PWM for the 4-digit seven-segment display. It produces the active-low one-hot anode pattern, the digit index for the segment-data mux, and an active-high PWM blanking signal. Both feed the downstream anode gating stage, which forces an anode off while `pwm` is high. Brightness is a 4-bit level, stepped by pushbutton pulses.

## Interface
- `SLOT_CYCLES`, default 16384: clock cycles per digit slot. Must be a multiple of 16 and at least 16.
- `LEVEL_RESET`, default 15: brightness level after reset, 0..15.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `bright_up` in 1: single-cycle pulse that raises the level by 1.
- `bright_down` in 1: single-cycle pulse that lowers the level by 1.
- `blank` in 1: when high, the whole display is dark.
- `sseg_an_control` out 4: active-low one-hot anode scan.
- `digit_sel` out 2: index of the active digit, for the segment mux.
- `pwm` out 1: 1 turns all anodes off.
- `level` out 4: current requested brightness.
- `slot_start` out 1: high in the first cycle of every slot.

## Operation
- **Slot counter** `slot_cnt`: counts 0..SLOT_CYCLES-1 and wraps to 0.
  - At the wrap, `digit_sel` advances 0→1→2→3→0.
  - `sseg_an_control` = ~(1 << digit_sel); it is a register updated in the same edge as `digit_sel`.
- **Phase**: `phase` = slot_cnt / (SLOT_CYCLES/16), range 0..15.
- **PWM output** (combinational from registers only): `pwm` = blank_q | (phase > level_eff).
  - Lit time per slot is (level_eff+1)/16.
  - level_eff=15 gives `pwm` = 0 for the whole slot, unless blanked.
  - level_eff=0 lights the digit for only the first SLOT_CYCLES/16 cycles.
- **`blank_q`**: `blank` registered once. Blanking takes effect 1 cycle after `blank` and does not stop the scan.
- **Level register** (`level`):
  - `bright_up` alone: +1, saturating at 15.
  - `bright_down` alone: −1, saturating at 0.
  - Both in the same cycle: no change.
  - Updates on the edge after the pulse.
- **Effective level** `level_eff`: loaded only on the edge where slot_cnt = SLOT_CYCLES-1. A level change therefore never alters the duty cycle mid-slot; it applies from the next `slot_start`.
- **Reset** (`rst_n` low at an edge) clears the state wherever it is:
  - slot_cnt=0, digit_sel=0, sseg_an_control=4'b1110
  - level=LEVEL_RESET, level_eff=LEVEL_RESET (see Configuration), blank_q=1
  - Resulting outputs: `pwm`=1, `slot_start`=1 (since slot_cnt=0).
  - Reset mid-slot aborts that slot; the display stays dark until blank_q clears.

## Timing
- One digit per SLOT_CYCLES cycles; frame = 4·SLOT_CYCLES.
- `slot_start` is high exactly when slot_cnt=0. In that cycle `digit_sel` and `sseg_an_control` already show the new digit.
- `pwm` edges occur only at phase boundaries: cycles where slot_cnt is a multiple of SLOT_CYCLES/16, or 1 cycle after a `blank` change.
- Latencies:
  - `bright_*` pulse → `level`: 1 cycle.
  - `level` → duty cycle: next slot boundary, at most SLOT_CYCLES cycles later.
- No glitches: `sseg_an_control` is registered; `pwm` depends only on registered state.

## Configuration
- Macro: `SSEG_SOFT_START_EN`.
- **Defined:**
  - level_eff resets to 0 instead of LEVEL_RESET.
  - At each frame boundary (digit 3→0 wrap), level_eff moves one step toward `level` (+1 or −1); it is unchanged if equal.
  - Brightness therefore ramps both after reset and on button changes.
  - Mid-frame slot boundaries do not update level_eff.
- **Undefined:** level_eff := level at every slot boundary, as described in Operation.

## Test plan
All scenarios use SLOT_CYCLES=64 (phase step 4 cycles), LEVEL_RESET=15, macro undefined unless stated.
1. **Scan order.** Release reset, blank=0 → `sseg_an_control` is 1110, 1101, 1011, 0111, 1110, changing every 64 cycles. `slot_start` pulses on each change. `digit_sel` is 0,1,2,3,0.
2. **Duty cycle.** 11 `bright_down` pulses (level 15→4) → from the next `slot_start`, `pwm`=0 for cycles 0..19 of each slot and 1 for cycles 20..63.
3. **Saturation and simultaneous pulses.**
   - 20 `bright_up` pulses at level 15 → `level` stays 15.
   - `bright_up` and `bright_down` in the same cycle → `level` unchanged.
   - 16 `bright_down` pulses → `level`=0, `pwm`=0 for only 4 cycles per slot.
4. **Mid-slot change.** At slot_cnt=30 with level 15, pulse `bright_down` 15 times → the current slot keeps `pwm`=0 through cycle 63. The next slot has `pwm`=0 only for cycles 0..3.
5. **Blank and reset.**
   - `blank`=1 → `pwm`=1 one cycle later while the scan continues.
   - `rst_n`=0 at slot_cnt=40 of digit 2 → the next cycle shows digit_sel=0, sseg_an_control=1110, pwm=1, level=15.
6. **Soft start (`SSEG_SOFT_START_EN`).** After reset, the lit cycles per slot are 4, 8, 12, … 64, increasing once per 256-cycle frame. Full brightness is reached after 15 frames.

Source files
------------

// File: rtl/sseg_scan_dimmer.sv
// Four-digit anode scan with per-slot PWM dimming; free-running, no backpressure, level applies from next slot start.
// Optional SSEG_SOFT_START_EN: effective level ramps one step per frame toward the requested level.
module sseg_scan_dimmer #(
  parameter int SLOT_CYCLES = 16384,
  parameter int LEVEL_RESET = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bright_up,
  input  logic       bright_down,
  input  logic       blank,
  output logic [3:0] sseg_an_control,
  output logic [1:0] digit_sel,
  output logic       pwm,
  output logic [3:0] level,
  output logic       slot_start
);

  localparam int PHASE_LEN = SLOT_CYCLES / 16;
  localparam int SW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(PHASE_LEN - 1);
  localparam logic [3:0] LVL_RST = 4'(LEVEL_RESET);
`ifdef SSEG_SOFT_START_EN
  localparam logic [3:0] EFF_RST = 4'd0;
`else
  localparam logic [3:0] EFF_RST = LVL_RST;
`endif

  // slot_cnt is held split as phase (upper) and sub-phase (lower) so the
  // phase compare needs no divider for non-power-of-two slot lengths.
  logic [SW-1:0] sub_q, sub_d;
  logic [3:0]    phase_q, phase_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    level_q, level_d;
  logic [3:0]    eff_q, eff_d;
  logic          blank_q, blank_d;
  logic          phase_end;
  logic          slot_end;

  always_comb begin
    sub_d     = sub_q;
    phase_d   = phase_q;
    digit_d   = digit_q;
    an_d      = an_q;
    level_d   = level_q;
    eff_d     = eff_q;
    blank_d   = blank;
    phase_end = (sub_q == SUB_LAST);
    slot_end  = phase_end && (phase_q == 4'd15);

    if (phase_end) begin
      sub_d   = '0;
      phase_d = phase_q + 4'd1;
    end else begin
      sub_d = sub_q + SW'(1);
    end

    if (slot_end) begin
      digit_d = digit_q + 2'd1;
      an_d    = ~(4'b0001 << digit_d);
`ifdef SSEG_SOFT_START_EN
      if (digit_q == 2'd3) begin
        if (level_q > eff_q) begin
          eff_d = eff_q + 4'd1;
        end else if (level_q < eff_q) begin
          eff_d = eff_q - 4'd1;
        end
      end
`else
      eff_d = level_q;
`endif
    end

    case ({bright_up, bright_down})
      2'b10:   if (level_q != 4'd15) level_d = level_q + 4'd1;
      2'b01:   if (level_q != 4'd0)  level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q   <= '0;
      phase_q <= 4'd0;
      digit_q <= 2'd0;
      an_q    <= 4'b1110;
      level_q <= LVL_RST;
      eff_q   <= EFF_RST;
      blank_q <= 1'b1;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      level_q <= level_d;
      eff_q   <= eff_d;
      blank_q <= blank_d;
    end
  end

  assign slot_start      = (sub_q == '0) && (phase_q == 4'd0);
  assign pwm             = blank_q | (phase_q > eff_q);
  assign sseg_an_control = an_q;
  assign digit_sel       = digit_q;
  assign level           = level_q;

endmodule

// File: tb/tb_sseg_scan_dimmer.sv
// Randomized and directed bench for sseg_scan_dimmer against a cycle-count reference model.
module tb_sseg_scan_dimmer;
  localparam int SLOT = 64;
  localparam int PL   = SLOT / 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bright_up = 1'b0;
  logic       bright_down = 1'b0;
  logic       blank = 1'b1;
  logic [3:0] sseg_an_control;
  logic [1:0] digit_sel;
  logic       pwm;
  logic [3:0] level;
  logic       slot_start;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: absolute position in the slot, digit number, levels.
  int m_cnt = 0, m_dig = 0, m_lvl = 15, m_eff = 15, m_blank = 1;
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  sseg_scan_dimmer #(.SLOT_CYCLES(SLOT), .LEVEL_RESET(15)) dut (
    .clk(clk), .rst_n(rst_n), .bright_up(bright_up), .bright_down(bright_down),
    .blank(blank), .sseg_an_control(sseg_an_control), .digit_sel(digit_sel),
    .pwm(pwm), .level(level), .slot_start(slot_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_dig = 0; m_lvl = 15; m_blank = 1;
`ifdef SSEG_SOFT_START_EN
      m_eff = 0;
`else
      m_eff = 15;
`endif
    end else begin
      if (m_cnt == SLOT - 1) begin
`ifdef SSEG_SOFT_START_EN
        if (m_dig == 3) begin
          if (m_lvl > m_eff) m_eff = m_eff + 1;
          else if (m_lvl < m_eff) m_eff = m_eff - 1;
        end
`else
        m_eff = m_lvl;
`endif
        m_dig = (m_dig + 1) % 4;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (bright_up && !bright_down && m_lvl < 15) m_lvl = m_lvl + 1;
      if (bright_down && !bright_up && m_lvl > 0) m_lvl = m_lvl - 1;
      m_blank = blank ? 1 : 0;
    end
  end

  function automatic logic exp_pwm();
    return (m_blank != 0) || ((m_cnt / PL) > m_eff);
  endfunction

  task automatic wait_cnt(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * SLOT + 2; i++) begin
      @(negedge clk);
      if (m_cnt == c) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic hold(input logic up, input logic dn, input int n);
    bright_up = up; bright_down = dn;
    repeat (n) @(negedge clk);
    bright_up = 1'b0; bright_down = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; blank = 1'b1; bright_up = 1'b0; bright_down = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (sseg_an_control !== 4'b1110) $display("FAIL reset_an got %b want 1110", sseg_an_control); else n_pass++;
    n_chk++; if (digit_sel !== 2'd0) $display("FAIL reset_digit got %0d want 0", digit_sel); else n_pass++;
    n_chk++; if (pwm !== 1'b1) $display("FAIL reset_pwm got %b want 1", pwm); else n_pass++;
    n_chk++; if (level !== 4'd15) $display("FAIL reset_level got %0d want 15", level); else n_pass++;
    n_chk++; if (slot_start !== 1'b1) $display("FAIL reset_slot_start got %b want 1", slot_start); else n_pass++;
    rst_n = 1'b1; blank = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] seq [$];
    for (int i = 0; i < 4 * SLOT; i++) begin
      @(negedge clk);
      n_chk++; if (sseg_an_control !== an_tab[m_dig]) $display("FAIL scan_an cyc=%0d got %b want %b", i, sseg_an_control, an_tab[m_dig]); else n_pass++;
      n_chk++; if (digit_sel !== 2'(m_dig)) $display("FAIL scan_digit cyc=%0d got %0d want %0d", i, digit_sel, m_dig); else n_pass++;
      n_chk++; if (slot_start !== (m_cnt == 0)) $display("FAIL scan_slot_start cyc=%0d got %b want %b", i, slot_start, m_cnt == 0); else n_pass++;
      if (slot_start === 1'b1) seq.push_back(sseg_an_control);
    end
    n_chk++; if (seq.size() != 4) $display("FAIL scan_pulses got %0d want 4", seq.size()); else n_pass++;
    if (seq.size() == 4) begin
      n_chk++; if (seq[0] !== 4'b1101 || seq[1] !== 4'b1011 || seq[2] !== 4'b0111 || seq[3] !== 4'b1110)
        $display("FAIL scan_order got %b %b %b %b want 1101 1011 0111 1110", seq[0], seq[1], seq[2], seq[3]);
      else n_pass++;
    end
  endtask

  task automatic test_duty();
    bit ok;
    hold(1'b0, 1'b1, 11);
    n_chk++; if (level !== 4'd4) $display("FAIL duty_level got %0d want 4", level); else n_pass++;
    wait_cnt(0, ok);
    n_chk++; if (!ok) $display("FAIL duty_wait got timeout want slot_start"); else n_pass++;
    for (int i = 0; i < SLOT; i++) begin
      if (i > 0) @(negedge clk);
      n_chk++; if (pwm !== (i >= 20)) $display("FAIL duty_pwm cyc=%0d got %b want %b", i, pwm, i >= 20); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    bit ok;
    int lit;
    hold(1'b1, 1'b0, 31);
    n_chk++; if (level !== 4'd15) $display("FAIL sat_up got %0d want 15", level); else n_pass++;
    hold(1'b0, 1'b1, 6);
    hold(1'b1, 1'b1, 3);
    n_chk++; if (level !== 4'd9) $display("FAIL sat_both got %0d want 9", level); else n_pass++;
    hold(1'b0, 1'b1, 16);
    n_chk++; if (level !== 4'd0) $display("FAIL sat_down got %0d want 0", level); else n_pass++;
    wait_cnt(0, ok);
    n_chk++; if (!ok) $display("FAIL sat_wait got timeout want slot_start"); else n_pass++;
    lit = 0;
    for (int i = 0; i < SLOT; i++) begin
      if (i > 0) @(negedge clk);
      if (pwm === 1'b0) lit++;
      n_chk++; if (pwm !== (i >= 4)) $display("FAIL sat_pwm cyc=%0d got %b want %b", i, pwm, i >= 4); else n_pass++;
    end
    n_chk++; if (lit != 4) $display("FAIL sat_lit got %0d want 4", lit); else n_pass++;
  endtask

  task automatic test_mid_slot();
    bit ok;
    hold(1'b1, 1'b0, 15);
    wait_cnt(0, ok);
    wait_cnt(30, ok);
    n_chk++; if (!ok) $display("FAIL mid_wait got timeout want cnt 30"); else n_pass++;
    for (int k = 0; k < SLOT - 30; k++) begin
      n_chk++; if (pwm !== 1'b0) $display("FAIL mid_cur_pwm cnt=%0d got %b want 0", 30 + k, pwm); else n_pass++;
      bright_down = (k < 15);
      @(negedge clk);
    end
    bright_down = 1'b0;
    n_chk++; if (level !== 4'd0) $display("FAIL mid_level got %0d want 0", level); else n_pass++;
    for (int i = 0; i < SLOT; i++) begin
      if (i > 0) @(negedge clk);
      n_chk++; if (pwm !== (i >= 4)) $display("FAIL mid_next_pwm cyc=%0d got %b want %b", i, pwm, i >= 4); else n_pass++;
    end
  endtask

  task automatic test_blank_reset();
    bit ok;
    int d0;
    hold(1'b1, 1'b0, 6);
    wait_cnt(0, ok);
    wait_cnt(0, ok);
    n_chk++; if (pwm !== 1'b0) $display("FAIL blank_pre got %b want 0", pwm); else n_pass++;
    blank = 1'b1;
    @(negedge clk);
    n_chk++; if (pwm !== 1'b1) $display("FAIL blank_pwm got %b want 1", pwm); else n_pass++;
    d0 = int'(digit_sel);
    repeat (SLOT) @(negedge clk);
    n_chk++; if (digit_sel !== 2'((d0 + 1) % 4)) $display("FAIL blank_scan got %0d want %0d", digit_sel, (d0 + 1) % 4); else n_pass++;
    n_chk++; if (pwm !== 1'b1) $display("FAIL blank_hold got %b want 1", pwm); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 5 * SLOT; i++) begin
      @(negedge clk);
      if (m_dig == 2 && m_cnt == 40) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++; if (!ok) $display("FAIL rst_wait got timeout want digit 2 cnt 40"); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (digit_sel !== 2'd0) $display("FAIL rst_digit got %0d want 0", digit_sel); else n_pass++;
    n_chk++; if (sseg_an_control !== 4'b1110) $display("FAIL rst_an got %b want 1110", sseg_an_control); else n_pass++;
    n_chk++; if (pwm !== 1'b1) $display("FAIL rst_pwm got %b want 1", pwm); else n_pass++;
    n_chk++; if (level !== 4'd15) $display("FAIL rst_level got %0d want 15", level); else n_pass++;
    rst_n = 1'b1; blank = 1'b0;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_chk++; if (sseg_an_control !== an_tab[m_dig]) $display("FAIL rnd_an cyc=%0d got %b want %b", i, sseg_an_control, an_tab[m_dig]); else n_pass++;
      n_chk++; if (digit_sel !== 2'(m_dig)) $display("FAIL rnd_digit cyc=%0d got %0d want %0d", i, digit_sel, m_dig); else n_pass++;
      n_chk++; if (pwm !== exp_pwm()) $display("FAIL rnd_pwm cyc=%0d got %b want %b", i, pwm, exp_pwm()); else n_pass++;
      n_chk++; if (level !== 4'(m_lvl)) $display("FAIL rnd_level cyc=%0d got %0d want %0d", i, level, m_lvl); else n_pass++;
      n_chk++; if (slot_start !== (m_cnt == 0)) $display("FAIL rnd_slot_start cyc=%0d got %b want %b", i, slot_start, m_cnt == 0); else n_pass++;
      r = int'($urandom_range(0, 9));
      bright_up   = (r < 2) || (r == 4);
      bright_down = (r == 2) || (r == 3) || (r == 4);
      if ($urandom_range(0, 49) == 0) blank = ~blank;
    end
    bright_up = 1'b0; bright_down = 1'b0; blank = 1'b0;
  endtask

`ifdef SSEG_SOFT_START_EN
  task automatic test_soft_start();
    int lit;
    for (int f = 0; f < 16; f++) begin
      lit = 0;
      for (int i = 0; i < 4 * SLOT; i++) begin
        if (i < SLOT && pwm === 1'b0) lit++;
        @(negedge clk);
      end
      if (f > 0) begin
        n_chk++; if (lit != 4 * (f + 1)) $display("FAIL soft_lit frame=%0d got %0d want %0d", f, lit, 4 * (f + 1)); else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SSEG_SOFT_START_EN
    test_soft_start();
    test_reset();
`else
    test_scan();
    test_duty();
    test_saturation();
    test_mid_slot();
    test_blank_reset();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
